// File: rtl/clint_timer_pkg.sv
// ---------------------------------------------------------------------------
// clint_timer_pkg
// Shared definitions for the core-local interruptor:
//   - register offsets relative to the CLINT base address
//   - register-select enum produced by the offset decoder
//   - decode_offset : maps a byte offset onto a register select
//   - merge_bytes   : byte-lane merge of write data into a 32-bit word
// ---------------------------------------------------------------------------
package clint_timer_pkg;

    localparam logic [15:0] clint_msip_off     = 16'h0000;
    localparam logic [15:0] clint_mtimecmp_off = 16'h4000;
    localparam logic [15:0] clint_mtime_off    = 16'hBFF8;

    typedef enum logic [2:0] {
        sel_none,
        sel_msip,
        sel_cmp_lo,
        sel_cmp_hi,
        sel_time_lo,
        sel_time_hi
    } reg_sel_e;

    // Offsets beyond the 64 KiB window never alias onto a register.
    function automatic reg_sel_e decode_offset(input logic [31:0] offset);
        reg_sel_e sel;
        sel = sel_none;
        if (offset[31:16] == 16'h0000) begin
            case (offset[15:0])
                clint_msip_off:                  sel = sel_msip;
                clint_mtimecmp_off:              sel = sel_cmp_lo;
                clint_mtimecmp_off + 16'h0004:   sel = sel_cmp_hi;
                clint_mtime_off:                 sel = sel_time_lo;
                clint_mtime_off + 16'h0004:      sel = sel_time_hi;
                default:                         sel = sel_none;
            endcase
        end
        return sel;
    endfunction

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] merged;
        merged = old_word;
        for (int i = 0; i < 4; i++) begin
            if (wstrb[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/clint_timer_if.sv
// ---------------------------------------------------------------------------
// clint_bus_if
// Native memory bus between the upstream decoder/arbiter (master) and the
// CLINT (slave).
//   mem_valid  request strobe, one cycle per request
//   mem_instr  instruction-fetch flag (not used by the CLINT)
//   mem_addr   word-aligned byte address
//   mem_wdata  write data
//   mem_wstrb  byte enables, all zero means read
//   mem_rdata  read data, valid while mem_ready is high
//   mem_ready  one-cycle response strobe
// ---------------------------------------------------------------------------
interface clint_bus_if;

    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    modport master (
        output mem_valid,
        output mem_instr,
        output mem_addr,
        output mem_wdata,
        output mem_wstrb,
        input  mem_rdata,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_instr,
        input  mem_addr,
        input  mem_wdata,
        input  mem_wstrb,
        output mem_rdata,
        output mem_ready
    );

endinterface

// File: rtl/clint_timer_rtc_tick.sv
// ---------------------------------------------------------------------------
// clint_rtc_tick
// Divides the system clock down to the RTC rate used by mtime.
//   clock  system clock, rising edge
//   reset  synchronous, active-high
//   tick   single-cycle pulse; mtime advances on the edge that ends it
// A counter runs 0..DIVIDER and toggles a phase bit each time it wraps.
// The tick marks the phase falling from 1 to 0, giving one tick every
// 2*(DIVIDER+1) clocks.
// ---------------------------------------------------------------------------
module clint_rtc_tick #(
    parameter int DIVIDER = 4
) (
    input  logic clock,
    input  logic reset,
    output logic tick
);

    localparam int CW = (DIVIDER < 1) ? 1 : $clog2(DIVIDER + 1);
    localparam logic [CW-1:0] LAST = CW'(DIVIDER);

    logic [CW-1:0] count;
    logic          phase;
    logic          wrap;

    assign wrap = (count == LAST);

    // Combinational so the tick lines up with the edge on which the phase
    // falls; the consumer samples it on that same edge.
    assign tick = wrap && phase;

    always_ff @(posedge clock) begin
        if (reset) begin
            count <= '0;
            phase <= 1'b0;
        end else if (wrap) begin
            count <= '0;
            phase <= ~phase;
        end else begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/clint_timer.sv
// ---------------------------------------------------------------------------
// clint_timer
// Core-local interruptor: msip, a 64-bit mtime advanced by the RTC and a
// 64-bit mtimecmp, all reachable over the native memory bus.
//   clock        system clock, rising edge
//   reset        synchronous, active-high
//   bus          clint_bus_if slave port (request in, one-cycle response out)
//   clint_msip   machine software interrupt pending
//   clint_mtip   machine timer interrupt pending (registered compare)
//   clint_mtime  current mtime for the time/timeh CSRs
// Every request gets mem_ready exactly one cycle after it is sampled; there
// are no wait states, so back-to-back requests stream through.
// ---------------------------------------------------------------------------
module clint_timer
    import clint_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR       = 32'h0200_0000,
    parameter int          CLK_DIVIDER_RTC = 4
) (
    input  logic               clock,
    input  logic               reset,
    clint_bus_if.slave         bus,
    output logic               clint_msip,
    output logic               clint_mtip,
    output logic [63:0]        clint_mtime
);

    logic [31:0] offset;
    reg_sel_e    sel;
    logic        write_en;
    logic [31:0] read_word;
    logic        tick;

    logic        msip;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic        mtip;
    logic        ready;
    logic [31:0] rdata;

    logic        unused_instr;
    assign unused_instr = bus.mem_instr;

    clint_rtc_tick #(
        .DIVIDER (CLK_DIVIDER_RTC)
    ) u_rtc_tick (
        .clock (clock),
        .reset (reset),
        .tick  (tick)
    );

    assign offset   = bus.mem_addr - BASE_ADDR;
    assign sel      = decode_offset(offset);
    assign write_en = bus.mem_valid && (bus.mem_wstrb != 4'b0000);

    // Read data is taken from the registers as they stand before this edge,
    // so a same-edge RTC increment or write is not visible yet.
    always_comb begin
        read_word = 32'h0000_0000;
        case (sel)
            sel_msip:    read_word = {31'b0, msip};
            sel_cmp_lo:  read_word = mtimecmp[31:0];
            sel_cmp_hi:  read_word = mtimecmp[63:32];
            sel_time_lo: read_word = mtime[31:0];
            sel_time_hi: read_word = mtime[63:32];
            default:     read_word = 32'h0000_0000;
        endcase
    end

    // Response register: one ready pulse per sampled request.
    always_ff @(posedge clock) begin
        if (reset) begin
            ready <= 1'b0;
            rdata <= 32'h0000_0000;
        end else begin
            ready <= bus.mem_valid;
            rdata <= bus.mem_valid ? read_word : 32'h0000_0000;
        end
    end

    // msip and mtimecmp only change on bus writes. msip has a single
    // implemented bit, living in byte lane 0.
    always_ff @(posedge clock) begin
        if (reset) begin
            msip     <= 1'b0;
            mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
        end else if (write_en) begin
            if (sel == sel_msip && bus.mem_wstrb[0]) begin
                msip <= bus.mem_wdata[0];
            end
            if (sel == sel_cmp_lo) begin
                mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], bus.mem_wdata, bus.mem_wstrb);
            end
            if (sel == sel_cmp_hi) begin
                mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], bus.mem_wdata, bus.mem_wstrb);
            end
        end
    end

    // A bus write to either mtime half takes priority over the RTC: the
    // written half takes the new bytes, the other half holds, and that
    // edge's tick is simply lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            mtime <= 64'h0;
        end else if (write_en && sel == sel_time_lo) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], bus.mem_wdata, bus.mem_wstrb);
        end else if (write_en && sel == sel_time_hi) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], bus.mem_wdata, bus.mem_wstrb);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    // Timer interrupt compares the current register values, so it trails
    // any update of mtime or mtimecmp by one cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            mtip <= 1'b0;
        end else begin
            mtip <= (mtime >= mtimecmp);
        end
    end

    assign bus.mem_ready = ready;
    assign bus.mem_rdata = rdata;
    assign clint_msip    = msip;
    assign clint_mtip    = mtip;
    assign clint_mtime   = mtime;

endmodule

// File: tb/tb_clint_timer.sv
// ---------------------------------------------------------------------------
// tb_clint_timer
// Self-checking bench for clint_timer. A behavioural model (tick every
// 2*(divider+1) clocks since reset, register map as a case on the offset)
// is stepped on every rising edge; a compare process checks the DUT against
// it on every falling edge. Directed scenarios add literal expectations,
// followed by a randomized burst of reads and writes.
// ---------------------------------------------------------------------------
module tb_clint_timer;

    localparam logic [31:0] BASE = 32'h0200_0000;
    localparam int          DIV  = 4;
    localparam int          TICK_PERIOD = 2 * (DIV + 1);

    logic        clock;
    logic        reset;
    logic        clint_msip;
    logic        clint_mtip;
    logic [63:0] clint_mtime;

    clint_bus_if bus ();

    clint_timer #(
        .BASE_ADDR       (BASE),
        .CLK_DIVIDER_RTC (DIV)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .clint_msip  (clint_msip),
        .clint_mtip  (clint_mtip),
        .clint_mtime (clint_mtime)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check_output(input string name, input logic [63:0] actual,
                                input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Behavioural model state
    bit          model_live = 0;
    int unsigned edges_since_reset;
    bit          m_msip;
    logic [63:0] m_time;
    logic [63:0] m_cmp;
    bit          m_mtip;
    bit          m_ready;
    logic [31:0] m_rdata;

    function automatic logic [31:0] model_merge(input logic [31:0] old_word,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  wstrb);
        logic [31:0] r;
        r = old_word;
        for (int i = 0; i < 4; i++) if (wstrb[i]) r[8*i +: 8] = wdata[8*i +: 8];
        return r;
    endfunction

    always @(posedge clock) begin
        logic [31:0] off;
        logic [31:0] rd;
        bit          tick_now;
        bit          time_written;
        model_live <= 1;
        if (reset) begin
            edges_since_reset = 0;
            m_msip  = 0;
            m_time  = 64'h0;
            m_cmp   = 64'hFFFF_FFFF_FFFF_FFFF;
            m_mtip  = 0;
            m_ready = 0;
            m_rdata = 32'h0;
        end else begin
            edges_since_reset++;
            tick_now = (edges_since_reset % TICK_PERIOD) == 0;
            off = bus.mem_addr - BASE;
            case (off)
                32'h0000: rd = {31'b0, m_msip};
                32'h4000: rd = m_cmp[31:0];
                32'h4004: rd = m_cmp[63:32];
                32'hBFF8: rd = m_time[31:0];
                32'hBFFC: rd = m_time[63:32];
                default:  rd = 32'h0;
            endcase
            m_ready = bus.mem_valid;
            m_rdata = bus.mem_valid ? rd : 32'h0;
            m_mtip  = (m_time >= m_cmp);
            time_written = 0;
            if (bus.mem_valid && bus.mem_wstrb != 4'h0) begin
                case (off)
                    32'h0000: if (bus.mem_wstrb[0]) m_msip = bus.mem_wdata[0];
                    32'h4000: m_cmp[31:0]  = model_merge(m_cmp[31:0], bus.mem_wdata, bus.mem_wstrb);
                    32'h4004: m_cmp[63:32] = model_merge(m_cmp[63:32], bus.mem_wdata, bus.mem_wstrb);
                    32'hBFF8: begin
                        m_time[31:0] = model_merge(m_time[31:0], bus.mem_wdata, bus.mem_wstrb);
                        time_written = 1;
                    end
                    32'hBFFC: begin
                        m_time[63:32] = model_merge(m_time[63:32], bus.mem_wdata, bus.mem_wstrb);
                        time_written = 1;
                    end
                    default: ;
                endcase
            end
            if (tick_now && !time_written) m_time = m_time + 64'd1;
        end
    end

    // Compare process: outputs are checked mid-cycle, away from the edge.
    always @(negedge clock) begin
        if (model_live) begin
            check_output("model_ready", {63'b0, bus.mem_ready}, {63'b0, m_ready});
            if (m_ready) check_output("model_rdata", {32'b0, bus.mem_rdata}, {32'b0, m_rdata});
            check_output("model_msip",  {63'b0, clint_msip}, {63'b0, m_msip});
            check_output("model_mtip",  {63'b0, clint_mtip}, {63'b0, m_mtip});
            check_output("model_mtime", clint_mtime, m_time);
        end
    end

    // One request; returns the response seen one cycle later.
    task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] wdata,
                                  input logic [3:0] wstrb,
                                  output logic [31:0] rdata, output logic ready);
        @(negedge clock);
        bus.mem_valid = 1'b1;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = addr;
        bus.mem_wdata = wdata;
        bus.mem_wstrb = wstrb;
        @(negedge clock);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        rdata = bus.mem_rdata;
        ready = bus.mem_ready;
    endtask

    // Returns at the falling edge right after mtime next changes.
    task automatic wait_tick();
        logic [63:0] prev;
        bit seen;
        prev = clint_mtime;
        seen = 0;
        for (int i = 0; i < 4 * TICK_PERIOD && !seen; i++) begin
            @(negedge clock);
            if (clint_mtime !== prev) seen = 1;
        end
        if (!seen) check_output("tick_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        logic [31:0] rd;
        logic        rdy;
        bit          found;
        logic [31:0] offs [8];
        offs = '{32'h0000, 32'h4000, 32'h4004, 32'hBFF8, 32'hBFFC, 32'h0008, 32'h0004, 32'hBFF4};

        reset = 1'b1;
        bus.mem_valid = 1'b0;
        bus.mem_instr = 1'b0;
        bus.mem_addr  = 32'h0;
        bus.mem_wdata = 32'h0;
        bus.mem_wstrb = 4'h0;
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // 1: idle 100 clocks -> mtime 10
        repeat (100) @(posedge clock);
        #1;
        check_output("idle_mtime", clint_mtime, 64'd10);
        check_output("idle_mtip",  {63'b0, clint_mtip}, 64'd0);
        check_output("idle_msip",  {63'b0, clint_msip}, 64'd0);
        apply_stimulus(BASE + 32'hBFF8, 32'h0, 4'h0, rd, rdy);
        check_output("read_mtime_lo", {32'b0, rd}, 64'd10);
        check_output("read_ready", {63'b0, rdy}, 64'd1);
        @(negedge clock);
        check_output("ready_one_cycle", {63'b0, bus.mem_ready}, 64'd0);

        // 2: msip
        apply_stimulus(BASE, 32'h1, 4'hF, rd, rdy);
        check_output("msip_set", {63'b0, clint_msip}, 64'd1);
        apply_stimulus(BASE, 32'h0, 4'h0, rd, rdy);
        check_output("msip_read", {32'b0, rd}, 64'd1);
        apply_stimulus(BASE, 32'h0, 4'hF, rd, rdy);
        check_output("msip_clear", {63'b0, clint_msip}, 64'd0);
        apply_stimulus(BASE, 32'hFFFF_FFFE, 4'hF, rd, rdy);
        check_output("msip_even", {63'b0, clint_msip}, 64'd0);

        // 3: mtimecmp = 20, mtime from 0
        apply_stimulus(BASE + 32'h4004, 32'h0, 4'hF, rd, rdy);
        apply_stimulus(BASE + 32'h4000, 32'h14, 4'hF, rd, rdy);
        apply_stimulus(BASE + 32'hBFF8, 32'h0, 4'hF, rd, rdy);
        apply_stimulus(BASE + 32'hBFFC, 32'h0, 4'hF, rd, rdy);
        found = 0;
        for (int i = 0; i < 400 && !found; i++) begin
            @(negedge clock);
            if (clint_mtime == 64'd20) found = 1;
        end
        check_output("mtime_reach_20", {63'b0, found}, 64'd1);
        check_output("mtip_lag", {63'b0, clint_mtip}, 64'd0);
        @(negedge clock);
        check_output("mtip_rise", {63'b0, clint_mtip}, 64'd1);
        apply_stimulus(BASE + 32'h4004, 32'h1, 4'hF, rd, rdy);
        @(negedge clock);
        check_output("mtip_fall", {63'b0, clint_mtip}, 64'd0);

        // 4: carry into the high half, then full wrap
        wait_tick();
        apply_stimulus(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, rdy);
        apply_stimulus(BASE + 32'hBFFC, 32'h0, 4'hF, rd, rdy);
        wait_tick();
        check_output("mtime_carry", clint_mtime, 64'h1_0000_0000);
        apply_stimulus(BASE + 32'hBFF8, 32'hFFFF_FFFF, 4'hF, rd, rdy);
        apply_stimulus(BASE + 32'hBFFC, 32'hFFFF_FFFF, 4'hF, rd, rdy);
        wait_tick();
        check_output("mtime_wrap", clint_mtime, 64'h0);

        // 5: write lands on the tick edge; tick is dropped
        repeat (8) @(negedge clock);
        apply_stimulus(BASE + 32'hBFF8, 32'h55, 4'hF, rd, rdy);
        check_output("tick_edge_write", clint_mtime, 64'h55);
        repeat (9) @(negedge clock);
        check_output("tick_hold", clint_mtime, 64'h55);
        @(negedge clock);
        check_output("tick_next", clint_mtime, 64'h56);

        // 6: unmapped offset, then reset during a request
        apply_stimulus(BASE + 32'h0008, 32'h1234, 4'hF, rd, rdy);
        check_output("unmapped_ready", {63'b0, rdy}, 64'd1);
        check_output("unmapped_rdata", {32'b0, rd}, 64'd0);
        apply_stimulus(BASE + 32'h4000, 32'h0, 4'h0, rd, rdy);
        check_output("cmp_lo_kept", {32'b0, rd}, 64'h14);
        apply_stimulus(BASE, 32'h1, 4'h1, rd, rdy);
        @(negedge clock);
        bus.mem_valid = 1'b1;
        bus.mem_addr  = BASE + 32'hBFF8;
        bus.mem_wstrb = 4'h0;
        reset = 1'b1;
        @(negedge clock);
        bus.mem_valid = 1'b0;
        reset = 1'b0;
        check_output("rst_ready", {63'b0, bus.mem_ready}, 64'd0);
        check_output("rst_msip",  {63'b0, clint_msip}, 64'd0);
        check_output("rst_mtime", clint_mtime, 64'd0);
        check_output("rst_mtip",  {63'b0, clint_mtip}, 64'd0);
        apply_stimulus(BASE + 32'h4004, 32'h0, 4'h0, rd, rdy);
        check_output("rst_cmp_hi", {32'b0, rd}, 64'hFFFF_FFFF);

        // Randomized traffic, including back-to-back requests
        for (int i = 0; i < 800; i++) begin
            @(negedge clock);
            bus.mem_valid = ($urandom_range(0, 2) != 0);
            bus.mem_instr = $urandom_range(0, 1) == 1;
            bus.mem_addr  = BASE + offs[$urandom_range(0, 7)];
            bus.mem_wdata = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : $urandom;
            bus.mem_wstrb = ($urandom_range(0, 1) == 1) ? 4'h0 : 4'($urandom_range(0, 15));
        end
        @(negedge clock);
        bus.mem_valid = 1'b0;
        bus.mem_wstrb = 4'h0;
        repeat (5) @(negedge clock);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
